// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared fetch constants and types
package pc_fetch_pkg;
  localparam int PC_STEP = 4;
  typedef enum logic {FETCH_RUN, FETCH_HALT} fetch_state_e;
endpackage

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry FIFO with flush; the head register keeps its last value when empty
module fetch_buf #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [1:0]   count,
  output logic [W-1:0] head
);
  logic [W-1:0] tail;
  logic slot;
  assign slot = count > {1'b0, pop};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= '0;
      head <= '0;
      tail <= '0;
    end else if (flush) count <= '0;
    else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      head <= pop && count == 2'd2 ? tail : push && !slot ? din : head;
      tail <= push && slot ? din : tail;
    end
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: PC, ROM issue and IF/ID hand-off; FETCH_MISALIGN_CHK_EN adds a sticky misaligned-redirect halt
module pc_fetch
  import pc_fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              resetNIn,
  input  logic              enable,
  input  logic              branchTakenIn,
  input  logic [ADDR_W-1:0] branchAddrIn,
  output logic              romReqOut,
  output logic [ADDR_W-1:0] romAddrOut,
  input  logic [DATA_W-1:0] romDataIn,
  output logic              validOut,
  output logic [ADDR_W-1:0] addrOut,
  output logic [DATA_W-1:0] dataOut
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic              misalignOut
`endif
);
  logic [ADDR_W-1:0] pc_reg, inflight_addr, tgt;
  logic inflight, halt, bad, redir, pop, issue;
  logic [1:0] count;
  logic [2:0] occ;
  assign tgt = {branchAddrIn[ADDR_W-1:2], 2'b00};
`ifdef FETCH_MISALIGN_CHK_EN
  fetch_state_e state;
  assign halt = state == FETCH_HALT;
  assign bad = branchTakenIn && !halt && branchAddrIn[1:0] != 2'b00;
  assign misalignOut = halt;
  always_ff @(posedge clk or negedge resetNIn)
    if (!resetNIn) state <= FETCH_RUN;
    else if (bad) state <= FETCH_HALT;
`else
  logic unused_lo;
  assign unused_lo = ^branchAddrIn[1:0];
  assign halt = 1'b0;
  assign bad = 1'b0;
`endif
  assign redir = branchTakenIn && !halt;
  assign validOut = count != 2'd0;
  assign pop = enable && validOut && !redir;
  assign occ = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign issue = !halt && occ < 3'd2;
  assign romReqOut = redir ? !bad : issue;
  assign romAddrOut = redir ? tgt : pc_reg;
  always_ff @(posedge clk or negedge resetNIn)
    if (!resetNIn) begin
      pc_reg <= RESET_PC;
      inflight <= 1'b0;
      inflight_addr <= '0;
    end else begin
      inflight <= romReqOut;
      if (romReqOut) begin
        pc_reg <= romAddrOut + ADDR_W'(PC_STEP);
        inflight_addr <= romAddrOut;
      end
    end
  fetch_buf #(.W(ADDR_W + DATA_W)) u_buf (
    .clk(clk),
    .rst_n(resetNIn),
    .flush(redir),
    .push(inflight),
    .pop(pop),
    .din({inflight_addr, romDataIn}),
    .count(count),
    .head({addrOut, dataOut})
  );
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: table-driven cycle vectors plus hand sequences for misalign, async reset and wraparound
module tb_pc_fetch;
  localparam logic [31:0] K = 32'h5A5A_5A5A;
  typedef struct {
    logic [3:0]  f;
    logic [31:0] ba;
    logic [31:0] ra;
    logic [31:0] a;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, br = 1'b0;
  logic [31:0] ba = '0, rom_data = '0;
  logic req, valid;
  logic [31:0] raddr, addr, data;
`ifdef FETCH_MISALIGN_CHK_EN
  logic mis;
`endif
  int checks = 0, errors = 0;
  vec_t tv[24];
  pc_fetch dut (
    .clk(clk),
    .resetNIn(rst_n),
    .enable(en),
    .branchTakenIn(br),
    .branchAddrIn(ba),
    .romReqOut(req),
    .romAddrOut(raddr),
    .romDataIn(rom_data),
    .validOut(valid),
    .addrOut(addr),
    .dataOut(data)
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    .misalignOut(mis)
`endif
  );
  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= raddr ^ K;
  function automatic vec_t mk(input logic [3:0] f, input logic [31:0] b, input logic [31:0] r, input logic [31:0] a);
    vec_t v;
    v.f = f;
    v.ba = b;
    v.ra = r;
    v.a = a;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic drive(input logic e, input logic b, input logic [31:0] a);
    en = e;
    br = b;
    ba = a;
    #1;
  endtask
  task automatic head_is(input string nm, input logic [31:0] a);
    chk({nm, " valid"}, 32'(valid), 32'd1);
    chk({nm, " addr"}, addr, a);
    chk({nm, " data"}, data, a ^ K);
  endtask
  initial begin
    // flags are {enable, branch, expected romReq, expected valid}
    tv[0]  = mk(4'b1010, 32'h0,   32'h0,   32'h0);
    tv[1]  = mk(4'b1010, 32'h0,   32'h4,   32'h0);
    tv[2]  = mk(4'b1011, 32'h0,   32'h8,   32'h0);
    tv[3]  = mk(4'b1011, 32'h0,   32'hC,   32'h4);
    tv[4]  = mk(4'b0001, 32'h0,   32'h0,   32'h8);
    tv[5]  = mk(4'b0001, 32'h0,   32'h0,   32'h8);
    tv[6]  = mk(4'b0001, 32'h0,   32'h0,   32'h8);
    tv[7]  = mk(4'b0001, 32'h0,   32'h0,   32'h8);
    tv[8]  = mk(4'b0001, 32'h0,   32'h0,   32'h8);
    tv[9]  = mk(4'b1011, 32'h0,   32'h10,  32'h8);
    tv[10] = mk(4'b1011, 32'h0,   32'h14,  32'hC);
    tv[11] = mk(4'b1011, 32'h0,   32'h18,  32'h10);
    tv[12] = mk(4'b1111, 32'h200, 32'h200, 32'h14);
    tv[13] = mk(4'b1010, 32'h0,   32'h204, 32'h0);
    tv[14] = mk(4'b1011, 32'h0,   32'h208, 32'h200);
    tv[15] = mk(4'b1011, 32'h0,   32'h20C, 32'h204);
    tv[16] = mk(4'b0001, 32'h0,   32'h0,   32'h208);
    tv[17] = mk(4'b0001, 32'h0,   32'h0,   32'h208);
    tv[18] = mk(4'b0111, 32'h100, 32'h100, 32'h208);
    tv[19] = mk(4'b0010, 32'h0,   32'h104, 32'h0);
    tv[20] = mk(4'b0001, 32'h0,   32'h0,   32'h100);
    tv[21] = mk(4'b1011, 32'h0,   32'h108, 32'h100);
    tv[22] = mk(4'b1011, 32'h0,   32'h10C, 32'h104);
    tv[23] = mk(4'b1011, 32'h0,   32'h110, 32'h108);
    repeat (2) @(negedge clk);
    #1;
    chk("reset valid", 32'(valid), 32'd0);
    chk("reset addr", addr, 32'h0);
    chk("reset data", data, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("reset misalign", 32'(mis), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      drive(tv[i].f[3], tv[i].f[2], tv[i].ba);
      chk($sformatf("c%0d req", i), 32'(req), 32'(tv[i].f[1]));
      if (tv[i].f[1]) chk($sformatf("c%0d romaddr", i), raddr, tv[i].ra);
      chk($sformatf("c%0d valid", i), 32'(valid), 32'(tv[i].f[0]));
      if (tv[i].f[0]) begin
        chk($sformatf("c%0d addr", i), addr, tv[i].a);
        chk($sformatf("c%0d data", i), data, tv[i].a ^ K);
      end
      @(negedge clk);
    end
    drive(1'b1, 1'b1, 32'h102);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("mis redirect req", 32'(req), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i == 1, 32'h400);
      chk($sformatf("halt%0d misalign", i), 32'(mis), 32'd1);
      chk($sformatf("halt%0d req", i), 32'(req), 32'd0);
      chk($sformatf("halt%0d valid", i), 32'(valid), 32'd0);
      @(negedge clk);
    end
`else
    chk("low bits req", 32'(req), 32'd1);
    chk("low bits romaddr", raddr, 32'h100);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0);
    chk("low bits n+1 valid", 32'(valid), 32'd0);
    chk("low bits n+1 romaddr", raddr, 32'h104);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0);
    head_is("low bits n+2", 32'h100);
    @(negedge clk);
`endif
    drive(1'b1, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("async reset valid", 32'(valid), 32'd0);
    chk("async reset addr", addr, 32'h0);
    chk("async reset data", data, 32'h0);
`ifdef FETCH_MISALIGN_CHK_EN
    chk("async reset misalign", 32'(mis), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 32'hFFFF_FFF8);
    chk("wrap0 req", 32'(req), 32'd1);
    chk("wrap0 romaddr", raddr, 32'hFFFF_FFF8);
    chk("wrap0 valid", 32'(valid), 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0);
    chk("wrap1 romaddr", raddr, 32'hFFFF_FFFC);
    chk("wrap1 valid", 32'(valid), 32'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0);
    chk("wrap2 romaddr", raddr, 32'h0);
    head_is("wrap2", 32'hFFFF_FFF8);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0);
    chk("wrap3 romaddr", raddr, 32'h4);
    head_is("wrap3", 32'hFFFF_FFFC);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0);
    head_is("wrap4", 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
